// File: rtl/clk_pkg.sv
// clk_pkg: state/error encodings and idle-level helper shared by clkdiv and clkrecv
package clk_pkg;
  typedef enum logic [2:0] {IDLE = 3'b001, RUNNING = 3'b010} state_t;
  typedef enum logic {ERR_NONE = 1'b0, ERR_SHORT = 1'b1} err_t;
  function automatic logic idle_level(input int idle_high);
    return idle_high != 0;
  endfunction
endpackage

// File: rtl/clkrecv_filter.sv
// clkrecv_filter: synchroniser plus glitch filter; toggle_o means level_o flips at the next edge
module clkrecv_filter
  import clk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 2,
  parameter int IDLE_HIGH   = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sclk_i,
  output logic level_o,
  output logic toggle_o
);
  localparam logic IDLE_LVL = idle_level(IDLE_HIGH);
  localparam int CW = FILTER > 1 ? $clog2(FILTER) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(FILTER - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0] cnt;
  logic differ;
  assign differ = sync[SYNC_STAGES-1] != level_o;
  assign toggle_o = differ && cnt == '0;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      sync <= {SYNC_STAGES{IDLE_LVL}};
      level_o <= IDLE_LVL;
      cnt <= RELOAD;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], sclk_i};
      level_o <= level_o ^ toggle_o;
      cnt <= differ && !toggle_o ? cnt - 1'b1 : RELOAD;
    end
endmodule

// File: rtl/clkrecv.sv
// clkrecv: serial-clock receiver with burst FSM, gap/short detection and edge strobes.
// Define CLKRECV_PERIOD_EN to add the period_o/period_valid_o measurement.
module clkrecv
  import clk_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 2,
  parameter int IDLE_HIGH   = 1,
  parameter int MIN_HALF    = 4,
  parameter int TIMEOUT     = 32
`ifdef CLKRECV_PERIOD_EN
  , parameter int PERIOD_WIDTH = 16
`endif
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sclk_i,
  input  logic enable_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o,
  output logic active_o,
  output logic done_o,
  output logic stuck_o,
  output logic short_o
`ifdef CLKRECV_PERIOD_EN
  , output logic [PERIOD_WIDTH-1:0] period_o,
  output logic period_valid_o
`endif
);
  localparam logic IDLE_LVL = idle_level(IDLE_HIGH);
  localparam int GW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  err_t err;
  logic toggle, leave, ret, tmo, strobe;
  logic [GW-1:0] gap;
  clkrecv_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILTER(FILTER),
    .IDLE_HIGH(IDLE_HIGH)
  ) u_filter (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .sclk_i(sclk_i),
    .level_o(sclk_o),
    .toggle_o(toggle)
  );
  // gap is one less than the cycles elapsed since the last edge at the edge being evaluated
  always_comb begin
    leave = toggle && sclk_o == IDLE_LVL;
    ret = toggle && sclk_o != IDLE_LVL;
    tmo = state == RUNNING && !toggle && gap == GW'(TIMEOUT - 1);
    strobe = state == RUNNING ? toggle : leave && enable_i;
    err = state == RUNNING && toggle && gap < GW'(MIN_HALF - 1) ? ERR_SHORT : ERR_NONE;
    state_n = state == RUNNING ? ((ret && !enable_i) || tmo ? IDLE : RUNNING)
                               : (state == IDLE && leave && enable_i ? RUNNING : IDLE);
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      gap <= '0;
      {rise_o, fall_o, done_o, stuck_o, short_o} <= '0;
    end else begin
      state <= state_n;
      gap <= toggle ? '0 : gap == GW'(TIMEOUT) ? gap : gap + 1'b1;
      rise_o <= strobe && !sclk_o;
      fall_o <= strobe && sclk_o;
      done_o <= (state == RUNNING && ret && !enable_i) || (tmo && sclk_o == IDLE_LVL);
      stuck_o <= tmo && sclk_o != IDLE_LVL;
      short_o <= err == ERR_SHORT;
    end
  assign active_o = state == RUNNING;
`ifdef CLKRECV_PERIOD_EN
  logic [PERIOD_WIDTH-1:0] pcnt, pinc;
  assign pinc = &pcnt ? pcnt : pcnt + 1'b1;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      pcnt <= '0;
      period_o <= '0;
      period_valid_o <= 1'b0;
    end else begin
      pcnt <= leave ? '0 : pinc;
      period_valid_o <= state == RUNNING && leave;
      if (state == RUNNING && leave) period_o <= pinc;
    end
`endif
endmodule

// File: tb/tb_clkrecv.sv
// tb_clkrecv: directed and randomized checks of clkrecv against a cycle-level behavioural model
module tb_clkrecv;
  localparam int S = 2, F = 2, MH = 4, TO = 32;
`ifdef CLKRECV_PERIOD_EN
  localparam int W = 24;
  logic [15:0] period_o;
  logic period_valid_o;
`else
  localparam int W = 7;
`endif
  logic clk_i = 0, rst_i = 1, sclk_i = 1, enable_i = 1;
  logic sclk_o, rise_o, fall_o, active_o, done_o, stuck_o, short_o;
  int errors = 0, checks = 0;
  bit hist[$];
  bit m_lvl, m_run, e_rise, e_fall, e_done, e_stuck, e_short, e_pv;
  int m_since, m_pc, e_per;

  clkrecv dut (
    .clk_i(clk_i), .rst_i(rst_i), .sclk_i(sclk_i), .enable_i(enable_i),
    .sclk_o(sclk_o), .rise_o(rise_o), .fall_o(fall_o), .active_o(active_o),
    .done_o(done_o), .stuck_o(stuck_o), .short_o(short_o)
`ifdef CLKRECV_PERIOD_EN
    , .period_o(period_o), .period_valid_o(period_valid_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Model: the filtered level flips once the input has disagreed with it for F samples,
  // S edges after sampling; burst rules applied on elapsed-cycle counts.
  task automatic tick();
    bit flip, leave, strobe, nl;
    @(posedge clk_i);
    {e_rise, e_fall, e_done, e_stuck, e_short, e_pv} = '0;
    strobe = 0;
    if (rst_i) begin
      hist = {};
      for (int j = 0; j < S + F; j++) hist.push_back(1'b1);
      m_lvl = 1; m_run = 0; m_since = 0; m_pc = 0; e_per = 0;
    end else begin
      hist.push_front(sclk_i);
      void'(hist.pop_back());
      flip = 1;
      for (int j = 0; j < F; j++) if (hist[S+j] == m_lvl) flip = 0;
      if (m_since < 1000) m_since++;
      if (m_pc < 65535) m_pc++;
      leave = flip && m_lvl;
      nl = m_lvl ^ flip;
      if (m_run) begin
        strobe = flip;
        e_short = flip && m_since < MH;
        if (leave) begin e_per = m_pc; e_pv = 1; end
        if (flip && !leave && !enable_i) begin e_done = 1; m_run = 0; end
        else if (!flip && m_since == TO) begin e_done = m_lvl; e_stuck = !m_lvl; m_run = 0; end
      end else if (leave && enable_i) begin
        strobe = 1; m_run = 1;
      end
      if (leave) m_pc = 0;
      if (flip) m_since = 0;
      e_rise = strobe && nl;
      e_fall = strobe && !nl;
      m_lvl = nl;
    end
    #1;
  endtask

  function automatic logic [W-1:0] got();
`ifdef CLKRECV_PERIOD_EN
    return {sclk_o, rise_o, fall_o, active_o, done_o, stuck_o, short_o, period_valid_o, period_o};
`else
    return {sclk_o, rise_o, fall_o, active_o, done_o, stuck_o, short_o};
`endif
  endfunction

  function automatic logic [W-1:0] want();
`ifdef CLKRECV_PERIOD_EN
    return {m_lvl, e_rise, e_fall, m_run, e_done, e_stuck, e_short, e_pv, 16'(e_per)};
`else
    return {m_lvl, e_rise, e_fall, m_run, e_done, e_stuck, e_short};
`endif
  endfunction

  task automatic test_reset();
    sclk_i = 1; enable_i = 1;
    for (int i = 0; i < 6; i++) begin
      rst_i = i < 3;
      tick();
      if (got() !== want()) begin errors++; $display("FAIL reset cyc=%0d got=%b want=%b", i, got(), want()); end
      checks++;
    end
    if ({sclk_o, rise_o, fall_o, active_o} !== 4'b1000) begin
      errors++; $display("FAIL reset_state got=%b want=1000", {sclk_o, rise_o, fall_o, active_o});
    end
    checks++;
  endtask

  task automatic test_burst();
    int fc = 0, rc = 0, dc = 0, sc = 0, ff = 0, r4 = 0, di = 0, ph;
    for (int i = 0; i < 76; i++) begin
      ph = i - 4;
      sclk_i = (i < 4 || ph >= 64) ? 1'b1 : ((ph / 8) % 2 == 1);
      enable_i = !(ph >= 48);
      tick();
      if (got() !== want()) begin errors++; $display("FAIL burst cyc=%0d got=%b want=%b", i, got(), want()); end
      checks++;
      if (fall_o) begin fc++; if (ff == 0) ff = i; end
      if (rise_o) begin rc++; if (rc == 4) r4 = i; end
      if (done_o) begin dc++; di = i; end
      if (short_o) sc++;
    end
    enable_i = 1;
    if (ff - 4 !== 3) begin errors++; $display("FAIL burst_latency got=%0d want=3", ff - 4); end
    if (fc !== 4 || rc !== 4) begin errors++; $display("FAIL burst_edges falls=%0d rises=%0d want=4/4", fc, rc); end
    if (dc !== 1 || di !== r4 || r4 == 0) begin errors++; $display("FAIL burst_done count=%0d at=%0d want 1 at %0d", dc, di, r4); end
    if (sc !== 0 || active_o !== 0) begin errors++; $display("FAIL burst_end shorts=%0d active=%b want 0/0", sc, active_o); end
    checks += 4;
  endtask

  task automatic test_glitch();
    int seg[18] = '{1,6, 0,1, 1,8, 0,8, 1,8, 0,1, 1,6, 0,2, 1,10};
    int k = 0, fidle = 0, lidle = 0, fc = 0;
    enable_i = 1;
    for (int s = 0; s < $size(seg); s += 2)
      for (int n = 0; n < seg[s+1]; n++) begin
        sclk_i = seg[s] != 0;
        tick();
        if (got() !== want()) begin errors++; $display("FAIL glitch cyc=%0d got=%b want=%b", k, got(), want()); end
        checks++;
        if (fall_o) fc++;
        if (s < 6 && fall_o) fidle++;
        if (s < 6 && !sclk_o) lidle++;
        k++;
      end
    if (fidle !== 0 || lidle !== 0) begin errors++; $display("FAIL glitch_idle falls=%0d low=%0d want 0/0", fidle, lidle); end
    if (fc !== 2) begin errors++; $display("FAIL glitch_falls got=%0d want=2", fc); end
    checks += 2;
  endtask

  task automatic test_short();
    int seg[10] = '{1,4, 0,3, 1,3, 0,8, 1,8};
    int k = 0, sc = 0, ss = 0;
    enable_i = 1;
    for (int s = 0; s < $size(seg); s += 2)
      for (int n = 0; n < seg[s+1]; n++) begin
        sclk_i = seg[s] != 0;
        tick();
        if (got() !== want()) begin errors++; $display("FAIL short cyc=%0d got=%b want=%b", k, got(), want()); end
        checks++;
        if (short_o) sc++;
        if (short_o && (rise_o || fall_o)) ss++;
        k++;
      end
    if (sc !== 2 || ss !== 2) begin errors++; $display("FAIL short_count got=%0d strobed=%0d want 2/2", sc, ss); end
    checks++;
  endtask

  task automatic test_stuck();
    int fi = -1, si = -1, rc = 0, dc = 0, act = 1;
    enable_i = 1;
    for (int i = 0; i < 50; i++) begin
      sclk_i = i >= 40;
      tick();
      if (got() !== want()) begin errors++; $display("FAIL stuck cyc=%0d got=%b want=%b", i, got(), want()); end
      checks++;
      if (fall_o && fi < 0) fi = i;
      if (stuck_o) begin si = i; act = active_o; end
      if (rise_o) rc++;
      if (done_o) dc++;
    end
    if (fi < 0 || si - fi !== 32) begin errors++; $display("FAIL stuck_time fall=%0d stuck=%0d want gap 32", fi, si); end
    if (act !== 0 || rc !== 0 || dc !== 0) begin errors++; $display("FAIL stuck_after active=%0d rises=%0d done=%0d want 0/0/0", act, rc, dc); end
    checks += 2;
  endtask

  task automatic test_rst_mid();
    int seg[21] = '{1,4,0, 0,8,0, 1,8,0, 0,6,0, 0,1,1, 0,10,0, 1,40,0};
    int k = 0;
    enable_i = 1;
    for (int s = 0; s < $size(seg); s += 3)
      for (int n = 0; n < seg[s+1]; n++) begin
        sclk_i = seg[s] != 0;
        rst_i = seg[s+2] != 0;
        tick();
        if (got() !== want()) begin errors++; $display("FAIL rst_mid cyc=%0d got=%b want=%b", k, got(), want()); end
        checks++;
        if (rst_i) begin
          if ({sclk_o, active_o, done_o} !== 3'b100) begin
            errors++; $display("FAIL rst_mid_state got=%b want=100", {sclk_o, active_o, done_o});
          end
          checks++;
        end
        k++;
      end
    rst_i = 0;
  endtask

`ifdef CLKRECV_PERIOD_EN
  task automatic test_period();
    int vc = 0, fc = 0, bad = 0, first = -1, f2 = -2;
    enable_i = 1;
    for (int i = 0; i < 140; i++) begin
      sclk_i = (i < 4 || i >= 100) ? 1'b1 : (((i - 4) / 8) % 2 == 1);
      enable_i = i < 90;
      tick();
      if (got() !== want()) begin errors++; $display("FAIL period cyc=%0d got=%b want=%b", i, got(), want()); end
      checks++;
      if (fall_o) begin fc++; if (fc == 2) f2 = i; end
      if (period_valid_o) begin vc++; if (first < 0) first = i; if (period_o !== 16) bad++; end
    end
    enable_i = 1;
    if (vc !== 5 || bad !== 0 || first !== f2) begin
      errors++; $display("FAIL period_load valids=%0d bad=%0d first=%0d want 5/0/%0d", vc, bad, first, f2);
    end
    checks++;
  endtask
`endif

  task automatic test_random();
    int len, k = 0;
    for (int s = 0; s < 250; s++) begin
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(28, 40) : $urandom_range(1, 10);
      sclk_i = ~sclk_i;
      if ($urandom_range(0, 5) == 0) enable_i = ~enable_i;
      for (int n = 0; n < len; n++) begin
        rst_i = $urandom_range(0, 299) == 0;
        tick();
        if (got() !== want()) begin errors++; $display("FAIL random cyc=%0d got=%b want=%b", k, got(), want()); end
        checks++;
        k++;
      end
    end
    rst_i = 0;
    enable_i = 1;
  endtask

  initial begin
    test_reset();
    test_burst();
    test_glitch();
    test_short();
    test_stuck();
    test_rst_mid();
`ifdef CLKRECV_PERIOD_EN
    test_period();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
